// File: rtl/alu_pkg.sv
// Shared ALU opcode encodings, flag bit positions and opcode classification.
package alu_pkg;

   typedef enum logic [3:0] {
      EQU            = 4'd0,
      LESS_THAN      = 4'd1,
      LESS_THAN_U    = 4'd2,
      GREATER_THAN   = 4'd3,
      GREATER_THAN_U = 4'd4,
      ADD            = 4'd5,
      ADD_U          = 4'd6,
      SUB_U          = 4'd7,
      SLL            = 4'd8,
      SRL            = 4'd9,
      SRA            = 4'd10,
      OR             = 4'd11,
      XOR            = 4'd12,
      AND            = 4'd13
   } alu_op_e;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   localparam logic [31:0] OP_MAX = 32'(AND);

   // Compare opcodes occupy the bottom of the encoding space.
   function automatic logic is_cmp_op(input logic [31:0] op);
      return op <= 32'(GREATER_THAN_U);
   endfunction

endpackage

// File: rtl/alu_res_fifo.sv
// Two-entry synchronous FIFO, head visible one cycle after a push into an empty FIFO.
// Push while full / pop while empty are ignored; when empty the head shows the last popped entry.
module alu_res_fifo #(
   parameter int WIDTH = 38
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] dout_o,
   output logic [1:0]       count_o
);

   logic [WIDTH-1:0] mem_q [2];
   logic             wr_ptr_q;
   logic             rd_ptr_q;
   logic [1:0]       count_q;
   logic [1:0]       count_d;
   logic             push_ok;
   logic             pop_ok;

   assign push_ok = push_i && (count_q != 2'd2);
   assign pop_ok  = pop_i && (count_q != 2'd0);

   always_comb begin
      count_d = count_q;
      if (push_ok && !pop_ok) begin
         count_d = count_q + 2'd1;
      end else if (pop_ok && !push_ok) begin
         count_d = count_q - 2'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (push_ok) begin
            mem_q[wr_ptr_q] <= din_i;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop_ok) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         count_q <= count_d;
      end
   end

   // An empty FIFO has just advanced past its last entry, which still sits in the other slot.
   assign dout_o  = (count_q == 2'd0) ? mem_q[~rd_ptr_q] : mem_q[rd_ptr_q];
   assign count_o = count_q;

   ptr_count_consistent: assert property (@(posedge clk) disable iff (!rst_n)
      (count_q <= 2'd2) && (count_q[0] == (wr_ptr_q ^ rd_ptr_q)));

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: derives cmp/illegal/sticky flags and buffers results in a 2-entry FIFO (1-cycle latency).
// in_ready drops when both entries are held; a same-cycle pop does not free a slot for a push.
module alu_result_stage
   import alu_pkg::*;
#(
   parameter int BITS_SIZE  = 32,
   parameter int CNTRL_SIZE = 4,
   parameter int DEPTH      = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [CNTRL_SIZE-1:0] in_cntrl,
   input  logic [BITS_SIZE-1:0]  in_out,
   input  logic                  in_neg,
   input  logic                  in_zero,
   input  logic                  in_carry,
   input  logic                  in_ovf,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [BITS_SIZE-1:0]  out_data,
   output logic [3:0]            out_flags,
   output logic                  out_cmp,
   output logic                  out_illegal,
   output logic [3:0]            sticky_flags,
   input  logic                  sticky_clr
);

   localparam int EW = BITS_SIZE + 6;

   logic          push;
   logic          pop;
   logic [1:0]    count;
   logic          illegal;
   logic          cmp;
   logic [3:0]    flags_in;
   logic [EW-1:0] entry;
   logic [EW-1:0] head;
   logic [3:0]    sticky_q;
   logic [3:0]    sticky_d;

   assign in_ready  = count < 2'(DEPTH);
   assign out_valid = count != 2'd0;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   assign illegal = 32'(in_cntrl) > OP_MAX;
   assign cmp     = is_cmp_op(32'(in_cntrl)) && in_zero;

   always_comb begin
      flags_in         = '0;
      flags_in[FLAG_N] = in_neg;
      flags_in[FLAG_Z] = in_zero;
      flags_in[FLAG_C] = in_carry;
      flags_in[FLAG_V] = in_ovf;
   end

   assign entry = illegal ? {1'b1, 1'b0, 4'b0000, {BITS_SIZE{1'b0}}}
                          : {1'b0, cmp, flags_in, in_out};

   // Clear takes effect before accumulation so a clear+push leaves exactly the new flags.
   always_comb begin
      sticky_d = sticky_clr ? 4'b0000 : sticky_q;
      if (push && !illegal) begin
         sticky_d = sticky_d | flags_in;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sticky_q <= 4'b0000;
      end else begin
         sticky_q <= sticky_d;
      end
   end

   alu_res_fifo #(
      .WIDTH (EW)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .pop_i   (pop),
      .din_i   (entry),
      .dout_o  (head),
      .count_o (count)
   );

   assign out_data     = head[BITS_SIZE-1:0];
   assign out_flags    = head[BITS_SIZE+3:BITS_SIZE];
   assign out_cmp      = head[BITS_SIZE+4];
   assign out_illegal  = head[BITS_SIZE+5];
   assign sticky_flags = sticky_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: each task drives one scenario and checks outputs 1ns after the clock edge.
module tb_alu_result_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_cntrl;
   logic [31:0] in_out;
   logic        in_neg, in_zero, in_carry, in_ovf;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [3:0]  out_flags;
   logic        out_cmp;
   logic        out_illegal;
   logic [3:0]  sticky_flags;
   logic        sticky_clr;

   int checks   = 0;
   int failures = 0;

   alu_result_stage dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_cntrl     (in_cntrl),
      .in_out       (in_out),
      .in_neg       (in_neg),
      .in_zero      (in_zero),
      .in_carry     (in_carry),
      .in_ovf       (in_ovf),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_flags    (out_flags),
      .out_cmp      (out_cmp),
      .out_illegal  (out_illegal),
      .sticky_flags (sticky_flags),
      .sticky_clr   (sticky_clr)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] c, input logic [31:0] d, input logic [3:0] f);
      in_valid = 1'b1;
      in_cntrl = c;
      in_out   = d;
      {in_neg, in_zero, in_carry, in_ovf} = f;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; in_cntrl = 4'd0; in_out = 32'd0;
      {in_neg, in_zero, in_carry, in_ovf} = 4'b0000;
      out_ready = 1'b0; sticky_clr = 1'b0;
      #3;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (out_data !== 32'd0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
      checks++; if ({out_flags, out_cmp, out_illegal} !== 6'd0) begin failures++; $display("FAIL reset_head_fields got=%b exp=000000", {out_flags, out_cmp, out_illegal}); end
      checks++; if (sticky_flags !== 4'b0000) begin failures++; $display("FAIL reset_sticky got=%b exp=0000", sticky_flags); end
      tick(); tick();
      rst_n = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
   endtask

   task automatic test_single_push();
      drive(4'd5, 32'h1414_1414, 4'b0000);
      tick();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", out_valid); end
      checks++; if (out_data !== 32'h1414_1414) begin failures++; $display("FAIL single_data got=%h exp=14141414", out_data); end
      checks++; if ({out_flags, out_cmp, out_illegal} !== 6'd0) begin failures++; $display("FAIL single_fields got=%b exp=000000", {out_flags, out_cmp, out_illegal}); end
      checks++; if (sticky_flags !== 4'b0000) begin failures++; $display("FAIL single_sticky got=%b exp=0000", sticky_flags); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_pop_empty got=%b exp=0", out_valid); end
      checks++; if (out_data !== 32'h1414_1414) begin failures++; $display("FAIL single_hold_data got=%h exp=14141414", out_data); end
   endtask

   task automatic test_compare();
      drive(4'd1, 32'h0000_0000, 4'b0100);
      tick();
      checks++; if (out_cmp !== 1'b1) begin failures++; $display("FAIL cmp_lt got=%b exp=1", out_cmp); end
      checks++; if (out_flags !== 4'b0100) begin failures++; $display("FAIL cmp_lt_flags got=%b exp=0100", out_flags); end
      drive(4'd9, 32'h0000_0000, 4'b0100);
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      checks++; if (out_cmp !== 1'b0) begin failures++; $display("FAIL cmp_srl got=%b exp=0", out_cmp); end
      checks++; if (out_flags[2] !== 1'b1) begin failures++; $display("FAIL cmp_srl_zflag got=%b exp=1", out_flags[2]); end
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL cmp_srl_valid got=%b exp=1", out_valid); end
      tick();
      out_ready = 1'b0;
      sticky_clr = 1'b1;
      tick();
      sticky_clr = 1'b0;
      checks++; if (sticky_flags !== 4'b0000) begin failures++; $display("FAIL cmp_sticky_clr got=%b exp=0000", sticky_flags); end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      drive(4'd5, 32'h1, 4'b0000);
      tick();
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_one got=%b exp=1", in_ready); end
      drive(4'd5, 32'h2, 4'b0000);
      tick();
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_full got=%b exp=0", in_ready); end
      drive(4'd5, 32'h3, 4'b0000);
      tick();
      in_valid = 1'b0;
      checks++; if (out_data !== 32'h1) begin failures++; $display("FAIL bp_head_first got=%h exp=1", out_data); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_after_pop got=%b exp=1", in_ready); end
      checks++; if (out_data !== 32'h2) begin failures++; $display("FAIL bp_head_second got=%h exp=2", out_data); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_third_dropped got=%b exp=0", out_valid); end
   endtask

   task automatic test_back_to_back();
      drive(4'd6, 32'h100, 4'b0000);
      tick();
      for (int i = 0; i < 10; i++) begin
         checks++; if (out_data !== 32'h100 + 32'(i)) begin failures++; $display("FAIL b2b_order i=%0d got=%h exp=%h", i, out_data, 32'h100 + 32'(i)); end
         drive(4'd6, 32'h101 + 32'(i), 4'b0000);
         out_ready = 1'b1;
         tick();
         checks++; if ({out_valid, in_ready} !== 2'b11) begin failures++; $display("FAIL b2b_count1 i=%0d got=%b exp=11", i, {out_valid, in_ready}); end
      end
      in_valid = 1'b0;
      checks++; if (out_data !== 32'h10A) begin failures++; $display("FAIL b2b_last got=%h exp=10a", out_data); end
      tick();
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drained got=%b exp=0", out_valid); end
   endtask

   task automatic test_sticky();
      out_ready = 1'b1;
      drive(4'd5, 32'h10, 4'b1000);
      tick();
      drive(4'd5, 32'h11, 4'b0010);
      tick();
      checks++; if (sticky_flags !== 4'b1010) begin failures++; $display("FAIL sticky_accum got=%b exp=1010", sticky_flags); end
      drive(4'd5, 32'h12, 4'b0001);
      sticky_clr = 1'b1;
      tick();
      sticky_clr = 1'b0;
      checks++; if (sticky_flags !== 4'b0001) begin failures++; $display("FAIL sticky_clr_push got=%b exp=0001", sticky_flags); end
      drive(4'd14, 32'hDEAD_BEEF, 4'b1111);
      tick();
      in_valid = 1'b0;
      checks++; if (out_illegal !== 1'b1) begin failures++; $display("FAIL illegal_flag got=%b exp=1", out_illegal); end
      checks++; if (out_data !== 32'd0) begin failures++; $display("FAIL illegal_data got=%h exp=0", out_data); end
      checks++; if ({out_flags, out_cmp} !== 5'd0) begin failures++; $display("FAIL illegal_fields got=%b exp=00000", {out_flags, out_cmp}); end
      checks++; if (sticky_flags !== 4'b0001) begin failures++; $display("FAIL illegal_sticky got=%b exp=0001", sticky_flags); end
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_mid_reset();
      drive(4'd5, 32'h55, 4'b0010);
      tick();
      drive(4'd5, 32'h66, 4'b0010);
      tick();
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL midrst_full got=%b exp=0", in_ready); end
      drive(4'd5, 32'h99, 4'b1000);
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", out_valid); end
      checks++; if (sticky_flags !== 4'b0000) begin failures++; $display("FAIL midrst_sticky got=%b exp=0000", sticky_flags); end
      checks++; if (out_data !== 32'd0) begin failures++; $display("FAIL midrst_data got=%h exp=0", out_data); end
      tick();
      rst_n = 1'b1;
      in_valid = 1'b0;
      tick();
      checks++; if ({out_valid, in_ready} !== 2'b01) begin failures++; $display("FAIL midrst_after got=%b exp=01", {out_valid, in_ready}); end
      drive(4'd5, 32'h77, 4'b0000);
      tick();
      in_valid = 1'b0;
      checks++; if (out_data !== 32'h77) begin failures++; $display("FAIL midrst_no_stale got=%h exp=77", out_data); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_single_entry got=%b exp=0", out_valid); end
   endtask

   initial begin
      test_reset();
      test_single_push();
      test_compare();
      test_backpressure();
      test_back_to_back();
      test_sticky();
      test_mid_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
